// File: rtl/m_axi_cmd.sv
// Single-outstanding AXI master: one command in, one single-beat AW/W/B or AR/R transaction out, one response back.
// Optional watchdog: define M_AXI_CMD_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module m_axi_cmd #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ID_W           = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ID_W-1:0]     cmd_id_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_write_o,
  output logic [ID_W-1:0]     rsp_id_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [1:0]          rsp_resp_o,
  output logic [ID_W-1:0]     awid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ID_W-1:0]     wid_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [ID_W-1:0]     bid_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic [ID_W-1:0]     arid_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [ID_W-1:0]     rid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [DATA_W/8-1:0] rstrb_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  write_q, write_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;

`ifdef M_AXI_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy;
`endif

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
`ifdef M_AXI_CMD_TIMEOUT_EN
    cnt_d     = cnt_q;
    busy      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          id_d    = cmd_id_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          wstrb_d = cmd_wstrb_i;
          write_d = cmd_write_i;
          rdata_d = '0;
          resp_d  = 2'b00;
`ifdef M_AXI_CMD_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (cmd_write_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; move on once both have handshaken.
        if (awvalid_q && awready_i) awvalid_d = 1'b0;
        if (wvalid_q && wready_i)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid_i) begin
          resp_d  = (bid_i != id_q) ? 2'b10 : bresp_i;
          state_d = RSP;
        end
      end
      RD_REQ: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid_i) begin
          rdata_d = rdata_i;
          resp_d  = (rid_i != id_q) ? 2'b10 : 2'b00;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef M_AXI_CMD_TIMEOUT_EN
    busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
           (state_q == RD_REQ) || (state_q == RD_DATA);
    if (busy) begin
      cnt_d = cnt_q + 1'b1;
      // A completion in the expiry cycle wins over the abort.
      if (state_d != RSP && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = RSP;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        resp_d    = 2'b10;
        rdata_d   = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
`ifdef M_AXI_CMD_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef M_AXI_CMD_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign bready_o    = (state_q == WR_RESP);
  assign rready_o    = (state_q == RD_DATA);
  assign rsp_valid_o = (state_q == RSP);

  assign rsp_write_o = write_q;
  assign rsp_id_o    = id_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;

  assign awid_o    = id_q;
  assign awaddr_o  = addr_q;
  assign awvalid_o = awvalid_q;
  assign wid_o     = id_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wlast_o   = wvalid_q;
  assign wvalid_o  = wvalid_q;
  assign arid_o    = id_q;
  assign araddr_o  = addr_q;
  assign arvalid_o = arvalid_q;

  // Single-beat reads: strobes and last carry no information here.
  logic unused_ok;
  assign unused_ok = ^{rstrb_i, rlast_i, 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_m_axi_cmd.sv
// Directed bench for m_axi_cmd: write/read paths, stalls, ID mismatch, reset abort, optional watchdog.
module tb_m_axi_cmd;
  localparam int ADDR_W = 32, DATA_W = 32, ID_W = 4;

  logic clk = 1'b0, areset = 1'b1;
  logic cmd_valid_i = 0, cmd_ready_o, cmd_write_i = 0;
  logic [ID_W-1:0] cmd_id_i = '0;
  logic [ADDR_W-1:0] cmd_addr_i = '0;
  logic [DATA_W-1:0] cmd_wdata_i = '0;
  logic [DATA_W/8-1:0] cmd_wstrb_i = '0;
  logic rsp_valid_o, rsp_ready_i = 0, rsp_write_o;
  logic [ID_W-1:0] rsp_id_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic [1:0] rsp_resp_o;
  logic [ID_W-1:0] awid_o, wid_o, arid_o;
  logic [ADDR_W-1:0] awaddr_o, araddr_o;
  logic awvalid_o, awready_i = 0, wlast_o, wvalid_o, wready_i = 0;
  logic [DATA_W-1:0] wdata_o;
  logic [DATA_W/8-1:0] wstrb_o;
  logic [ID_W-1:0] bid_i = '0, rid_i = '0;
  logic [1:0] bresp_i = '0;
  logic bvalid_i = 0, bready_o, arvalid_o, arready_i = 0;
  logic [DATA_W-1:0] rdata_i = '0;
  logic [DATA_W/8-1:0] rstrb_i = '0;
  logic rlast_i = 0, rvalid_i = 0, rready_o;

  int n_cmp = 0, n_err = 0;

  m_axi_cmd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .areset(areset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_id_i(cmd_id_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_id_o(rsp_id_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rstrb_i(rstrb_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and checks both happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
    cmd_valid_i = 1; cmd_write_i = wr; cmd_id_i = id;
    cmd_addr_i = a; cmd_wdata_i = d; cmd_wstrb_i = s;
  endtask

  initial begin
    step(); step();
    areset = 0;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_valids", {awvalid_o, wvalid_o, arvalid_o, rsp_valid_o}, 0);
    chk("rst_readys", {bready_o, rready_o}, 0);
    chk("rst_payload", {awaddr_o, awid_o, wdata_o}, 0);

    // Zero-wait write
    awready_i = 1; wready_i = 1; rsp_ready_i = 1;
    issue(1, 4'd3, 32'h4, 32'hDEADBEEF, 4'hF);
    step();
    cmd_valid_i = 0;
    chk("wr_valids_n1", {awvalid_o, wvalid_o, wlast_o}, 3'b111);
    chk("wr_aw_payload", {awid_o, wid_o, awaddr_o}, {4'd3, 4'd3, 32'h4});
    chk("wr_w_payload", {wdata_o, wstrb_o}, {32'hDEADBEEF, 4'hF});
    chk("wr_cmd_ready_low", cmd_ready_o, 0);
    step();
    chk("wr_valids_drop", {awvalid_o, wvalid_o, bready_o}, 3'b001);
    bvalid_i = 1; bid_i = 4'd3; bresp_i = 2'b00;
    step();
    bvalid_i = 0;
    chk("wr_rsp_n3", {rsp_valid_o, rsp_write_o, rsp_id_o, rsp_resp_o}, {1'b1, 1'b1, 4'd3, 2'b00});
    chk("wr_rsp_rdata0", rsp_rdata_o, 0);
    step();
    chk("wr_back_idle", {rsp_valid_o, cmd_ready_o}, 2'b01);

    // Zero-wait read
    arready_i = 1;
    issue(0, 4'd5, 32'h4, 32'h0, 4'h0);
    step();
    cmd_valid_i = 0;
    chk("rd_ar", {arvalid_o, arid_o, araddr_o, awvalid_o}, {1'b1, 4'd5, 32'h4, 1'b0});
    step();
    chk("rd_ar_drop", {arvalid_o, rready_o}, 2'b01);
    rvalid_i = 1; rid_i = 4'd5; rdata_i = 32'hDEADBEEF;
    step();
    rvalid_i = 0;
    chk("rd_rsp", {rsp_valid_o, rsp_write_o, rsp_id_o, rsp_resp_o}, {1'b1, 1'b0, 4'd5, 2'b00});
    chk("rd_rdata", rsp_rdata_o, 32'hDEADBEEF);
    step();
    chk("rd_back_idle", {rsp_valid_o, cmd_ready_o}, 2'b01);

    // AW stalled four cycles, W immediate; early B must stay unconsumed
    awready_i = 0;
    issue(1, 4'd7, 32'h8, 32'h12345678, 4'h3);
    step();
    cmd_valid_i = 0;
    chk("aws_n1", {awvalid_o, wvalid_o}, 2'b11);
    bvalid_i = 1; bid_i = 4'd7; bresp_i = 2'b01;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("aws_hold", {awvalid_o, wvalid_o, bready_o}, 3'b100);
      step();
    end
    awready_i = 1;
    chk("aws_hold_last", {awvalid_o, wvalid_o, bready_o}, 3'b100);
    step();
    chk("aws_wr_resp", {awvalid_o, bready_o}, 2'b01);
    step();
    chk("aws_rsp", {rsp_valid_o, rsp_write_o, rsp_id_o, rsp_resp_o}, {1'b1, 1'b1, 4'd7, 2'b01});
    chk("aws_b_not_reconsumed", bready_o, 0);
    step();
    bvalid_i = 0;
    chk("aws_idle", {rsp_valid_o, cmd_ready_o, bready_o}, 3'b010);

    // Read with wrong RID, response back-pressured for three cycles
    rsp_ready_i = 0;
    issue(0, 4'd5, 32'h10, 32'h0, 4'h0);
    step();
    cmd_valid_i = 0;
    step();
    rvalid_i = 1; rid_i = 4'd6; rdata_i = 32'hA5A5A5A5;
    step();
    rvalid_i = 0;
    cmd_valid_i = 1; cmd_write_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk("idm_rsp_stable", {rsp_valid_o, rsp_id_o, rsp_resp_o, rsp_rdata_o},
          {1'b1, 4'd5, 2'b10, 32'hA5A5A5A5});
      chk("idm_cmd_ready_low", cmd_ready_o, 0);
      step();
    end
    cmd_valid_i = 0;
    rsp_ready_i = 1;
    chk("idm_rsp_last", {rsp_valid_o, rsp_resp_o}, 3'b110);
    step();
    chk("idm_idle", {rsp_valid_o, cmd_ready_o}, 2'b01);

    // Reset while waiting for B
    issue(1, 4'd2, 32'h20, 32'hCAFEF00D, 4'hF);
    step();
    cmd_valid_i = 0;
    step();
    chk("rstm_in_wr_resp", bready_o, 1);
    areset = 1;
    step();
    areset = 0;
    chk("rstm_valids", {awvalid_o, wvalid_o, arvalid_o, rsp_valid_o, bready_o}, 0);
    chk("rstm_cmd_ready", cmd_ready_o, 1);
    chk("rstm_payload", awaddr_o, 0);
    step();
    chk("rstm_no_rsp", rsp_valid_o, 0);

`ifdef M_AXI_CMD_TIMEOUT_EN
    begin
      int edges;
      edges = 0;
      arready_i = 0;
      issue(0, 4'd9, 32'h30, 32'h0, 4'h0);
      step();
      cmd_valid_i = 0;
      while (!rsp_valid_o && edges < 100) begin
        step();
        edges++;
      end
      chk("to_cycles", edges, 16);
      chk("to_rsp", {rsp_valid_o, rsp_resp_o, rsp_rdata_o, arvalid_o, rready_o},
          {1'b1, 2'b10, 32'h0, 1'b0, 1'b0});
      step();
      chk("to_idle", cmd_ready_o, 1);
    end
`else
    arready_i = 0;
    issue(0, 4'd9, 32'h30, 32'h0, 4'h0);
    step();
    cmd_valid_i = 0;
    repeat (40) step();
    chk("nto_waiting", {arvalid_o, rsp_valid_o}, 2'b10);
    arready_i = 1;
    step();
    rvalid_i = 1; rid_i = 4'd9; rdata_i = 32'h55;
    step();
    rvalid_i = 0;
    chk("nto_rsp", {rsp_valid_o, rsp_resp_o, rsp_rdata_o}, {1'b1, 2'b00, 32'h55});
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
